instr_fetch_queue: RTL and testbench

Instruction fetch front-end for the RISC-V core. It generates sequential fetch addresses and issues them to a latency-tolerant instruction memory port with a valid/ready request and in-order responses. Returned words are buffered with their PCs in a DEPTH-entry prefetch queue that feeds the decode/execute stage over a valid/ready handshake. A taken branch or jump from execute redirects fetch, flushes the queue and discards responses still in flight.

---
 rtl/instr_fetch_queue.sv | 83 ++++++++
 tb/tb_instr_fetch_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential fetch with credit-limited memory requests, a prefetch queue of {pc, instr},
// and redirect handling that flushes the queue and discards responses still in flight.
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        o_imem_req_valid,
   input  logic        i_imem_req_ready,
   output logic [31:0] o_imem_req_addr,
   input  logic        i_imem_rsp_valid,
   input  logic [31:0] i_imem_rsp_data,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [31:0] o_out_instr,
   output logic [31:0] o_out_pc,
   output logic [31:0] o_out_pc_plus4
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [31:0]   r_fetch_pc, r_resp_pc;
   logic [CW-1:0] r_inflight, r_drop, r_count;
   logic [AW-1:0] r_head, r_tail;
   logic [31:0]   r_pc_mem    [DEPTH];
   logic [31:0]   r_instr_mem [DEPTH];
   logic          w_fire, w_rsp, w_keep, w_pop;
   logic [CW-1:0] w_inflight_next;
   logic [CW:0]   w_credit;
   logic [31:0]   w_target;
   // in-flight requests plus queued entries never exceed DEPTH, so a kept response always has room
   assign w_credit         = {1'b0, r_inflight} + {1'b0, r_count};
   assign o_imem_req_valid = !rst && !i_redirect_valid && (w_credit < (CW+1)'(DEPTH));
   assign o_imem_req_addr  = r_fetch_pc;
   assign w_fire           = o_imem_req_valid && i_imem_req_ready;
   assign w_rsp            = i_imem_rsp_valid && (r_inflight != '0);
   assign w_keep           = w_rsp && (r_drop == '0) && !i_redirect_valid;
   assign w_pop            = o_out_valid && i_out_ready && !i_redirect_valid;
   assign w_inflight_next  = r_inflight + CW'(w_fire) - CW'(w_rsp);
   assign w_target         = i_redirect_pc & ~32'h3;
   assign o_out_valid      = r_count != '0;
   assign o_out_instr      = o_out_valid ? r_instr_mem[r_head] : '0;
   assign o_out_pc         = o_out_valid ? r_pc_mem[r_head] : '0;
   assign o_out_pc_plus4   = o_out_valid ? o_out_pc + 32'd4 : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_inflight <= '0;
         r_drop     <= '0;
         r_count    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
      end else begin
         r_inflight <= w_inflight_next;
         if (i_redirect_valid) begin
            r_fetch_pc <= w_target;
            r_resp_pc  <= w_target;
            r_drop     <= w_inflight_next;
            r_count    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
         end else begin
            if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_rsp && r_drop != '0) r_drop <= r_drop - CW'(1);
            if (w_keep) begin
               r_tail    <= r_tail + AW'(1);
               r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_pop) r_head <= r_head + AW'(1);
            r_count <= r_count + CW'(w_keep) - CW'(w_pop);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (w_keep) begin
         r_pc_mem[r_tail]    <= r_resp_pc;
         r_instr_mem[r_tail] <= i_imem_rsp_data;
      end
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed vectors against an in-order memory model with configurable latency,
// plus a second instance reset near the top of the address space to cover PC wrap.
module tb_instr_fetch_queue;
   logic        clk = 0, rst = 1;
   logic        req_valid, req_ready = 1, rsp_valid = 0, redirect_valid = 0, out_valid, out_ready = 0;
   logic [31:0] req_addr, rsp_data = 0, redirect_pc = 0, out_instr, out_pc, out_pc_plus4;
   logic        x_req_valid, x_rsp_valid = 0, x_out_valid;
   logic [31:0] x_req_addr, x_rsp_data = 0, x_out_instr, x_out_pc, x_out_pc_plus4;
   always #5 clk = ~clk;

   instr_fetch_queue u_dut (
      .clk(clk), .rst(rst),
      .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr),
      .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
      .i_redirect_valid(redirect_valid), .i_redirect_pc(redirect_pc),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_instr(out_instr),
      .o_out_pc(out_pc), .o_out_pc_plus4(out_pc_plus4));

   instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(rst),
      .o_imem_req_valid(x_req_valid), .i_imem_req_ready(1'b1), .o_imem_req_addr(x_req_addr),
      .i_imem_rsp_valid(x_rsp_valid), .i_imem_rsp_data(x_rsp_data),
      .i_redirect_valid(1'b0), .i_redirect_pc(32'h0),
      .o_out_valid(x_out_valid), .i_out_ready(1'b1), .o_out_instr(x_out_instr),
      .o_out_pc(x_out_pc), .o_out_pc_plus4(x_out_pc_plus4));

   typedef struct {logic [31:0] addr; int due;} mreq_t;
   typedef struct {logic [31:0] pc, instr, p4;} pop_t;
   typedef struct {logic ordy, rv; logic [31:0] ra; logic ov; logic [31:0] opc; logic wov; logic [31:0] wpc;} vec_t;
   mreq_t       mq[$];
   pop_t        got[$];
   logic [31:0] acc_addrs[$];
   int          checks = 0, errors = 0, cyc = 0, lat = 1;
   logic        x_pend = 0;
   logic [31:0] x_addr = 0;

   function automatic logic [31:0] memword(logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic chk_got(string n, int idx, logic [31:0] pc);
      if (got.size() <= idx) chk({n, " present"}, got.size(), idx + 1);
      else begin
         chk({n, " pc"}, got[idx].pc, pc);
         chk({n, " instr"}, got[idx].instr, memword(pc));
         chk({n, " pc_plus4"}, got[idx].p4, pc + 32'd4);
      end
   endtask

   // one clock: sample handshakes at negedge, then present responses that are due after the edge
   task automatic tick();
      @(negedge clk);
      if (rst) begin
         mq.delete();
         x_pend = 0;
      end else begin
         if (rsp_valid) void'(mq.pop_front());
         if (req_valid && req_ready) begin
            mq.push_back('{req_addr, cyc + lat});
            acc_addrs.push_back(req_addr);
         end
         if (out_valid && out_ready && !redirect_valid) got.push_back('{out_pc, out_instr, out_pc_plus4});
         x_pend = x_req_valid;
         x_addr = x_req_addr;
      end
      @(posedge clk);
      #1;
      cyc++;
      rsp_valid = mq.size() > 0 && mq[0].due <= cyc;
      rsp_data  = rsp_valid ? memword(mq[0].addr) : 32'h0;
      x_rsp_valid = x_pend;
      x_rsp_data  = memword(x_addr);
      x_pend = 0;
   endtask

   task automatic do_reset(int l);
      rst = 1;
      redirect_valid = 0;
      lat = l;
      repeat (3) tick();
      rst = 0;
      got.delete();
      acc_addrs.delete();
   endtask

   vec_t vt[15];

   initial begin
      vt[0]  = '{1, 1, 32'h00, 0, 32'h00, 0, 32'h0};
      vt[1]  = '{1, 1, 32'h04, 0, 32'h00, 0, 32'h0};
      vt[2]  = '{1, 1, 32'h08, 1, 32'h00, 1, 32'hFFFF_FFF8};
      vt[3]  = '{1, 1, 32'h0C, 1, 32'h04, 1, 32'hFFFF_FFFC};
      vt[4]  = '{1, 1, 32'h10, 1, 32'h08, 1, 32'h0000_0000};
      vt[5]  = '{1, 1, 32'h14, 1, 32'h0C, 1, 32'h04};
      vt[6]  = '{0, 1, 32'h18, 1, 32'h10, 1, 32'h08};
      vt[7]  = '{0, 1, 32'h1C, 1, 32'h10, 1, 32'h0C};
      vt[8]  = '{0, 0, 32'h00, 1, 32'h10, 1, 32'h10};
      vt[9]  = '{0, 0, 32'h00, 1, 32'h10, 1, 32'h14};
      vt[10] = '{1, 0, 32'h00, 1, 32'h10, 1, 32'h18};
      vt[11] = '{1, 1, 32'h20, 1, 32'h14, 1, 32'h1C};
      vt[12] = '{1, 1, 32'h24, 1, 32'h18, 1, 32'h20};
      vt[13] = '{1, 1, 32'h28, 1, 32'h1C, 1, 32'h24};
      vt[14] = '{1, 1, 32'h2C, 1, 32'h20, 1, 32'h28};

      // reset values, then stream / back-pressure table with a 1-cycle memory
      rst = 1;
      #1;
      chk("req_valid in reset", req_valid, 0);
      do_reset(1);
      for (int i = 0; i < 15; i++) begin
         out_ready = vt[i].ordy;
         #1;
         chk($sformatf("row%0d req_valid", i), req_valid, vt[i].rv);
         if (vt[i].rv) chk($sformatf("row%0d req_addr", i), req_addr, vt[i].ra);
         chk($sformatf("row%0d out_valid", i), out_valid, vt[i].ov);
         chk($sformatf("row%0d out_pc", i), out_pc, vt[i].ov ? vt[i].opc : 32'h0);
         chk($sformatf("row%0d out_instr", i), out_instr, vt[i].ov ? memword(vt[i].opc) : 32'h0);
         chk($sformatf("row%0d out_pc_plus4", i), out_pc_plus4, vt[i].ov ? vt[i].opc + 32'd4 : 32'h0);
         chk($sformatf("row%0d wrap out_valid", i), x_out_valid, vt[i].wov);
         if (vt[i].wov) begin
            chk($sformatf("row%0d wrap out_pc", i), x_out_pc, vt[i].wpc);
            chk($sformatf("row%0d wrap out_instr", i), x_out_instr, memword(vt[i].wpc));
            chk($sformatf("row%0d wrap pc_plus4", i), x_out_pc_plus4, vt[i].wpc + 32'd4);
         end
         tick();
      end
      got.delete();
      repeat (10) tick();
      chk("throughput pops", got.size(), 10);
      chk_got("stream first", 0, 32'h24);
      chk_got("stream last", 9, 32'h48);

      // 20 cycles of back-pressure, then drain
      do_reset(1);
      out_ready = 0;
      repeat (20) tick();
      #1;
      chk("bp requests", acc_addrs.size(), 4);
      chk("bp req_valid", req_valid, 0);
      chk("bp out_valid", out_valid, 1);
      acc_addrs.delete();
      out_ready = 1;
      repeat (8) tick();
      for (int i = 0; i < 5; i++) chk_got($sformatf("bp drain%0d", i), i, 32'(i * 4));
      chk("bp resume present", acc_addrs.size() > 0, 1);
      if (acc_addrs.size() > 0) chk("bp resume addr", acc_addrs[0], 32'h10);

      // redirect with 3 requests in flight, 3-cycle memory
      do_reset(3);
      out_ready = 1;
      for (int n = 0; n < 10 && mq.size() != 3; n++) tick();
      chk("rd1 inflight", mq.size(), 3);
      redirect_valid = 1;
      redirect_pc = 32'h100;
      #1;
      chk("rd1 req_valid in redirect", req_valid, 0);
      got.delete();
      tick();
      redirect_valid = 0;
      #1;
      chk("rd1 out_valid after", out_valid, 0);
      chk("rd1 req_valid after", req_valid, 1);
      chk("rd1 req_addr after", req_addr, 32'h100);
      repeat (15) tick();
      chk_got("rd1 first", 0, 32'h100);
      chk_got("rd1 second", 1, 32'h104);
      chk_got("rd1 third", 2, 32'h108);

      // redirect coinciding with a response and a pop, 1-cycle memory
      do_reset(1);
      out_ready = 1;
      repeat (4) tick();
      #1;
      chk("rd2 precondition", {rsp_valid, out_valid}, 2'b11);
      redirect_valid = 1;
      redirect_pc = 32'h203;
      #1;
      chk("rd2 req_valid in redirect", req_valid, 0);
      got.delete();
      tick();
      redirect_valid = 0;
      #1;
      chk("rd2 out_valid r+1", out_valid, 0);
      chk("rd2 req_addr r+1", req_addr, 32'h200);
      chk("rd2 req_valid r+1", req_valid, 1);
      tick();
      #1;
      chk("rd2 out_valid r+2", out_valid, 0);
      tick();
      #1;
      chk("rd2 out_valid r+3", out_valid, 1);
      chk("rd2 out_pc r+3", out_pc, 32'h200);
      repeat (4) tick();
      chk_got("rd2 first", 0, 32'h200);
      chk_got("rd2 second", 1, 32'h204);

      // reset mid-operation with requests in flight and entries queued
      do_reset(3);
      out_ready = 0;
      repeat (5) tick();
      #1;
      chk("mr precondition inflight", mq.size(), 2);
      chk("mr precondition queued", out_valid, 1);
      rst = 1;
      tick();
      #1;
      chk("mr out_valid", out_valid, 0);
      chk("mr req_valid in reset", req_valid, 0);
      rst = 0;
      acc_addrs.delete();
      #1;
      chk("mr restart valid", req_valid, 1);
      chk("mr restart addr", req_addr, 32'h0);
      repeat (10) tick();
      chk("mr full credit", acc_addrs.size(), 4);
      got.delete();
      out_ready = 1;
      repeat (12) tick();
      chk_got("mr first", 0, 32'h0);
      chk_got("mr second", 1, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
